// File: rtl/ic1337_pkg.sv
// rtl/ic1337_pkg.sv - shared mode encodings for the ic1337 register/flag bank
// Purpose: mode codes used by the bank top level and its bit-slices.
// Ports: none (package).
package ic1337_pkg;

  localparam logic [1:0] MODE_JK    = 2'd0;
  localparam logic [1:0] MODE_T     = 2'd1;
  localparam logic [1:0] MODE_D     = 2'd2;
  localparam logic [1:0] MODE_SHIFT = 2'd3;

endpackage

// File: rtl/ic1337_slice.sv
// rtl/ic1337_slice.sv - one-bit next-state logic for the JK, T and D modes
// Purpose: computes next q0/q1 of a single bit-slice from its current state
//   and operands. SHIFT needs neighbour bits, so the top level handles it; in
//   that mode this slice simply reports hold.
// Ports:
//   mode    in  2  operating mode (ic1337_pkg MODE_*)
//   q0, q1  in  1  current state of this slice
//   a0..a2  in  1  operand bits of this slice
//   q0_next out 1  next value of q0 (JK/T/D)
//   q1_next out 1  next value of q1 (JK/T/D)
module ic1337_slice
  import ic1337_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       q0,
  input  logic       q1,
  input  logic       a0,
  input  logic       a1,
  input  logic       a2,
  output logic       q0_next,
  output logic       q1_next
);

  always_comb begin
    q0_next = q0;
    q1_next = q1;
    case (mode)
      MODE_JK: begin
        // J = a0, K = a1: 00 hold, 01 clear, 10 set, 11 toggle
        case ({a0, a1})
          2'b01:   q0_next = 1'b0;
          2'b10:   q0_next = 1'b1;
          2'b11:   q0_next = ~q0;
          default: q0_next = q0;
        endcase
        q1_next = a2;
      end
      MODE_T: begin
        q0_next = q0 ^ a0;
        q1_next = q1 ^ a2;
      end
      MODE_D: begin
        q0_next = a0;
        q1_next = a1;
      end
      default: begin
        q0_next = q0;
        q1_next = q1;
      end
    endcase
  end

endmodule

// File: rtl/ic1337_bank.sv
// rtl/ic1337_bank.sv - WIDTH-slice two-flop register bank with match flags and counter
// Purpose: WIDTH bit-slices with state flops q0/q1 updated in JK/T/D/SHIFT
//   modes under a clock enable, per-bit match flags and a saturating count of
//   consecutive all-match cycles.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   en         in  1      q0/q1 update enable
//   mode       in  2      0=JK 1=T 2=D 3=SHIFT
//   a0, a1, a2 in  WIDTH  operand buses
//   q0, q1     out WIDTH  state registers
//   z          out WIDTH  per-bit match ~(q0 ^ q1)
//   z_all      out 1      all bits match
//   match_cnt  out CNT_W  consecutive-match count, saturating
//   z_hold     out 1      match_cnt >= HOLD_THRESH, registered
module ic1337_bank
  import ic1337_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 3,
  parameter int HOLD_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] z,
  output logic             z_all,
  output logic [CNT_W-1:0] match_cnt,
  output logic             z_hold
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(HOLD_THRESH);

  logic [WIDTH-1:0] slice_q0_next;
  logic [WIDTH-1:0] slice_q1_next;
  logic [WIDTH-1:0] q0_next;
  logic [WIDTH-1:0] q1_next;
  logic [CNT_W-1:0] cnt_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    ic1337_slice u_slice (
      .mode    (mode),
      .q0      (q0[i]),
      .q1      (q1[i]),
      .a0      (a0[i]),
      .a1      (a1[i]),
      .a2      (a2[i]),
      .q0_next (slice_q0_next[i]),
      .q1_next (slice_q1_next[i])
    );
  end

  // q0 shifts up with a0[0] entering at the bottom; q1 shifts down with
  // a2[WIDTH-1] entering at the top.
  always_comb begin
    q0_next = slice_q0_next;
    q1_next = slice_q1_next;
    if (mode == MODE_SHIFT) begin
      q0_next = {q0[WIDTH-2:0], a0[0]};
      q1_next = {a2[WIDTH-1], q1[WIDTH-1:1]};
    end
  end

  assign z     = ~(q0 ^ q1);
  assign z_all = &z;

  // Count uses the pre-edge z_all and sticks at its maximum.
  always_comb begin
    cnt_next = '0;
    if (z_all) begin
      cnt_next = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q0        <= '1;
      q1        <= '1;
      match_cnt <= '0;
      z_hold    <= 1'b0;
    end else begin
      if (en) begin
        q0 <= q0_next;
        q1 <= q1_next;
      end
      match_cnt <= cnt_next;
      z_hold    <= (cnt_next >= THRESH);
    end
  end

endmodule

// File: tb/tb_ic1337_bank.sv
// tb/tb_ic1337_bank.sv - self-checking bench for ic1337_bank
module tb_ic1337_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] a0 = '0;
  logic [3:0] a1 = '0;
  logic [3:0] a2 = '0;
  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] z;
  logic       z_all;
  logic [2:0] match_cnt;
  logic       z_hold;

  int total = 0;
  int bad = 0;

  // reference state (plain integers)
  int m_q0, m_q1, m_cnt, m_hold;

  always #5 clk = ~clk;

  ic1337_bank #(.WIDTH(4), .CNT_W(3), .HOLD_THRESH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .q0        (q0),
    .q1        (q1),
    .z         (z),
    .z_all     (z_all),
    .match_cnt (match_cnt),
    .z_hold    (z_hold)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge.
  task automatic model_edge(input int r, input int e, input int md,
                            input int x0, input int x1, input int x2);
    int matched;
    if (r != 0) begin
      m_q0 = 15; m_q1 = 15; m_cnt = 0; m_hold = 0;
      return;
    end
    matched = (m_q0 == m_q1);
    m_cnt   = matched ? ((m_cnt + 1 > 7) ? 7 : m_cnt + 1) : 0;
    m_hold  = (m_cnt >= 4);
    if (e != 0) begin
      case (md)
        0: begin
          // neither: keep; J only: set; K only: clear; both: invert
          m_q0 = ((m_q0 & ~x0 & ~x1) | (x0 & ~x1) | (~m_q0 & x0 & x1)) & 15;
          m_q1 = x2;
        end
        1: begin
          m_q0 = m_q0 ^ x0;
          m_q1 = m_q1 ^ x2;
        end
        2: begin
          m_q0 = x0;
          m_q1 = x1;
        end
        default: begin
          m_q0 = ((m_q0 * 2) + (x0 % 2)) % 16;
          m_q1 = (m_q1 / 2) + ((x2 / 8) % 2) * 8;
        end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q0"}, 8'(q0), 8'(m_q0));
    chk({tag, ".q1"}, 8'(q1), 8'(m_q1));
    chk({tag, ".z"}, 8'(z), 8'(15 - (m_q0 ^ m_q1)));
    chk({tag, ".z_all"}, 8'(z_all), 8'(m_q0 == m_q1));
    chk({tag, ".cnt"}, 8'(match_cnt), 8'(m_cnt));
    chk({tag, ".hold"}, 8'(z_hold), 8'(m_hold));
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input int r, input int e, input int md,
                      input int x0, input int x1, input int x2, input string tag);
    rst  = r[0];
    en   = e[0];
    mode = md[1:0];
    a0   = x0[3:0];
    a1   = x1[3:0];
    a2   = x2[3:0];
    @(posedge clk);
    model_edge(r, e, md, x0, x1, x2);
    #1;
    check_model(tag);
  endtask

  initial begin
    @(negedge clk);

    // T1 reset
    step(1, 0, 0, 0, 0, 0, "t1");
    chk("t1.q0c", 8'(q0), 8'hF);
    chk("t1.zc", 8'(z), 8'hF);
    chk("t1.cntc", 8'(match_cnt), 8'h0);

    // T2 JK from reset
    step(0, 1, 0, 4'b0101, 4'b0011, 4'b1010, "t2");
    chk("t2.q0c", 8'(q0), 8'b1100);
    chk("t2.q1c", 8'(q1), 8'b1010);
    chk("t2.zc", 8'(z), 8'b1001);
    chk("t2.zallc", 8'(z_all), 8'h0);
    step(0, 0, 0, 0, 0, 0, "t2b");
    chk("t2.cntc", 8'(match_cnt), 8'h0);

    // T3 T from reset, then enable low
    step(1, 0, 0, 0, 0, 0, "t3r");
    step(0, 1, 1, 4'b0011, 0, 4'b0001, "t3");
    chk("t3.q0c", 8'(q0), 8'b1100);
    chk("t3.q1c", 8'(q1), 8'b1110);
    step(0, 0, 1, 4'b1111, 0, 0, "t3h");
    chk("t3h.q0c", 8'(q0), 8'b1100);
    chk("t3h.q1c", 8'(q1), 8'b1110);

    // T4 SHIFT from reset
    step(1, 0, 0, 0, 0, 0, "t4r");
    step(0, 1, 3, 4'b0000, 0, 4'b0000, "t4a");
    chk("t4a.q0c", 8'(q0), 8'b1110);
    chk("t4a.q1c", 8'(q1), 8'b0111);
    step(0, 1, 3, 4'b0001, 0, 4'b1000, "t4b");
    chk("t4b.q0c", 8'(q0), 8'b1101);
    chk("t4b.q1c", 8'(q1), 8'b1011);

    // T5 saturation
    step(1, 0, 0, 0, 0, 0, "t5r");
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0, 0, 0, "t5");
      chk("t5.cntc", 8'(match_cnt), 8'((i > 7) ? 7 : i));
      chk("t5.holdc", 8'(z_hold), 8'(i >= 4));
    end

    // T6 mid-operation reset
    step(1, 0, 0, 0, 0, 0, "t6r");
    for (int i = 0; i < 5; i++) step(0, 1, 2, 4'b0110, 4'b0110, 0, "t6");
    chk("t6.cntc", 8'(match_cnt), 8'h5);
    chk("t6.holdc", 8'(z_hold), 8'h1);
    step(1, 1, 0, 4'b1111, 0, 0, "t6x");
    chk("t6x.q0c", 8'(q0), 8'hF);
    chk("t6x.q1c", 8'(q1), 8'hF);
    chk("t6x.cntc", 8'(match_cnt), 8'h0);
    chk("t6x.holdc", 8'(z_hold), 8'h0);

    // Randomized run; biased operands so matching streaks occur.
    for (int i = 0; i < 300; i++) begin
      int r, e, md, x0, x1, x2;
      r  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      md = $urandom_range(0, 3);
      x0 = $urandom_range(0, 15);
      x1 = ($urandom_range(0, 1) == 0) ? x0 : $urandom_range(0, 15);
      x2 = ($urandom_range(0, 1) == 0) ? x0 : $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) e = 0;
      step(r, e, md, x0, x1, x2, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
